// File: rtl/cpu_controller.sv
// Fetch/sequence stage for the 8-bit accumulator CPU: PC, IR and an 8-phase
// control sequencer whose strobes are pure decodes of state and IR.
module cpu_controller #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              alu_zero,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              data_oe,
  output logic [2:0]        alu_opcode,
  output logic              acc_ld,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [3:0] {
    S_INST_ADDR, S_INST_FETCH, S_INST_LOAD, S_IDLE,
    S_OP_ADDR, S_OP_FETCH, S_ALU_OP, S_STORE, S_HALT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] ir;
  logic [2:0]        op;
  logic [ADDR_W-1:0] ir_addr;
  logic              aluop, is_sto, fetch_ph, opnd_ph;

  assign op       = ir[DATA_W-1 -: 3];
  assign ir_addr  = ir[ADDR_W-1:0];
  assign aluop    = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
  assign is_sto   = (op == OP_STO);
  assign fetch_ph = (state == S_INST_FETCH) || (state == S_INST_LOAD) || (state == S_IDLE);
  assign opnd_ph  = (state == S_OP_FETCH) || (state == S_ALU_OP) || (state == S_STORE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_INST_ADDR;
      pc     <= '0;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_INST_ADDR:  state <= S_INST_FETCH;
        S_INST_FETCH: state <= S_INST_LOAD;
        S_INST_LOAD: begin
          ir    <= mem_rdata;
          state <= S_IDLE;
        end
        S_IDLE:       state <= S_OP_ADDR;
        S_OP_ADDR: begin
          if (op == OP_HLT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            pc    <= pc + ADDR_W'(1);
            state <= S_OP_FETCH;
          end
        end
        S_OP_FETCH:   state <= S_ALU_OP;
        S_ALU_OP: begin
          // alu_zero only matters here; SKZ and JMP cannot both apply
          if (op == OP_SKZ && alu_zero) pc <= pc + ADDR_W'(1);
          else if (op == OP_JMP)        pc <= ir_addr;
          state <= S_STORE;
        end
        S_STORE:      state <= S_INST_ADDR;
        default:      state <= S_HALT;
      endcase
    end
  end

  // Reset forces state to INST_ADDR, so every strobe clears without a clock.
  always_comb begin
    mem_addr   = fetch_ph || (state == S_INST_ADDR) ? pc : ir_addr;
    mem_rd     = fetch_ph || (opnd_ph && aluop);
    data_oe    = ((state == S_ALU_OP) || (state == S_STORE)) && is_sto;
    mem_wr     = (state == S_STORE) && is_sto;
    acc_ld     = (state == S_STORE) && aluop;
    alu_opcode = op;
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: small ROM model, hand-written per-phase
// strobe patterns (bit i = phase i of an instruction).
module tb_cpu_controller;
  logic       clk, rst, alu_zero;
  logic [7:0] mem_rdata;
  logic [4:0] mem_addr, pc;
  logic       mem_rd, mem_wr, data_oe, acc_ld, halted;
  logic [2:0] alu_opcode;
  logic [7:0] mem [32];
  int checks = 0, fails = 0;

  cpu_controller #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .alu_zero(alu_zero),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .data_oe(data_oe),
    .alu_opcode(alu_opcode), .acc_ld(acc_ld), .pc(pc), .halted(halted)
  );

  assign mem_rdata = mem[mem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one instruction starting at INST_ADDR, sampling at each negedge.
  task automatic instr(input string tag, input logic [4:0] pc0, input logic [7:0] op,
                       input logic [7:0] rdv, input logic [7:0] wrv, input logic [7:0] oev,
                       input logic [7:0] accv, input logic [4:0] pc1);
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("%s c%0d addr", tag, c), 32'(mem_addr), (c < 4) ? 32'(pc0) : 32'(op[4:0]));
      chk($sformatf("%s c%0d rd", tag, c), 32'(mem_rd), 32'(rdv[c]));
      chk($sformatf("%s c%0d wr", tag, c), 32'(mem_wr), 32'(wrv[c]));
      chk($sformatf("%s c%0d oe", tag, c), 32'(data_oe), 32'(oev[c]));
      chk($sformatf("%s c%0d acc", tag, c), 32'(acc_ld), 32'(accv[c]));
      if (c >= 3) chk($sformatf("%s c%0d opc", tag, c), 32'(alu_opcode), 32'(op[7:5]));
      if (c <= 4) chk($sformatf("%s c%0d pc", tag, c), 32'(pc), 32'(pc0));
      @(negedge clk);
    end
    chk({tag, " pc_end"}, 32'(pc), 32'(pc1));
    chk({tag, " halted"}, 32'(halted), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst pc", 32'(pc), 32'd0);
    chk("rst addr", 32'(mem_addr), 32'd0);
    chk("rst strobes", {28'd0, mem_rd, mem_wr, data_oe, acc_ld}, 32'd0);
    chk("rst opc", 32'(alu_opcode), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    alu_zero = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'hA3; mem[1] = 8'h44; mem[2] = 8'hE5; mem[3] = 8'h05; mem[4] = 8'h07;
    mem[5] = 8'h20; mem[6] = 8'hEA; mem[7] = 8'hE5; mem[10] = 8'hFF; mem[31] = 8'hC9;
    #2;
    do_reset();

    instr("lda3", 5'd0,  8'hA3, 8'b1110_1110, 8'h00, 8'h00, 8'b1000_0000, 5'd1);
    instr("add4", 5'd1,  8'h44, 8'b1110_1110, 8'h00, 8'h00, 8'b1000_0000, 5'd2);
    instr("jmp5", 5'd2,  8'hE5, 8'b0000_1110, 8'h00, 8'h00, 8'h00,        5'd5);
    alu_zero = 1'b1;
    instr("skz1", 5'd5,  8'h20, 8'b0000_1110, 8'h00, 8'h00, 8'h00,        5'd7);
    alu_zero = 1'b0;
    instr("jmpb", 5'd7,  8'hE5, 8'b0000_1110, 8'h00, 8'h00, 8'h00,        5'd5);
    instr("skz0", 5'd5,  8'h20, 8'b0000_1110, 8'h00, 8'h00, 8'h00,        5'd6);
    instr("jmpa", 5'd6,  8'hEA, 8'b0000_1110, 8'h00, 8'h00, 8'h00,        5'd10);
    instr("jmpf", 5'd10, 8'hFF, 8'b0000_1110, 8'h00, 8'h00, 8'h00,        5'd31);
    instr("sto9", 5'd31, 8'hC9, 8'b0000_1110, 8'b1000_0000, 8'b1100_0000, 8'h00, 5'd0);

    // reset in the middle of a store
    mem[0] = 8'hC9;
    do_reset();
    repeat (7) @(negedge clk);
    chk("midsto wr_pre", 32'(mem_wr), 32'd1);
    chk("midsto addr_pre", 32'(mem_addr), 32'd9);
    rst = 1'b1;
    #1;
    chk("midsto wr", 32'(mem_wr), 32'd0);
    chk("midsto oe", 32'(data_oe), 32'd0);
    chk("midsto pc", 32'(pc), 32'd0);
    chk("midsto addr", 32'(mem_addr), 32'd0);
    chk("midsto halted", 32'(halted), 32'd0);
    @(negedge clk);

    // halt at PC=2
    mem[0] = 8'hA3; mem[2] = 8'h00;
    do_reset();
    instr("h_lda", 5'd0, 8'hA3, 8'b1110_1110, 8'h00, 8'h00, 8'b1000_0000, 5'd1);
    instr("h_add", 5'd1, 8'h44, 8'b1110_1110, 8'h00, 8'h00, 8'b1000_0000, 5'd2);
    repeat (4) @(negedge clk);
    chk("hlt opaddr halted", 32'(halted), 32'd0);
    chk("hlt opaddr pc", 32'(pc), 32'd2);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      chk($sformatf("hlt c%0d halted", c), 32'(halted), 32'd1);
      chk($sformatf("hlt c%0d pc", c), 32'(pc), 32'd2);
      chk($sformatf("hlt c%0d strobes", c), {28'd0, mem_rd, mem_wr, data_oe, acc_ld}, 32'd0);
      chk($sformatf("hlt c%0d addr", c), 32'(mem_addr), 32'd0);
    end
    rst = 1'b1;
    #1;
    chk("hlt rst halted", 32'(halted), 32'd0);
    chk("hlt rst pc", 32'(pc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Fetch/sequence stage for the 8-bit accumulator RISC CPU. It sits directly upstream of the ALU.
- Owns the program counter (PC), the instruction register (IR) and an 8-phase control sequencer.
- Drives the memory address/read/write strobes, the ALU opcode and the accumulator load enable.
- Consumes the ALU zero flag for SKZ.
- Instruction word: opcode = bits [7:5] (`OPCODE_* from src/defines.v: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7); operand address = bits [4:0].

Parameters:
- ADDR_W, 5, width of PC, IR address field and mem_addr.
- DATA_W, 8, width of instruction/data words.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mem_rdata  input  DATA_W  memory read data; valid by the cycle after mem_rd rises.
- alu_zero  input  1  ALU is_zero (accumulator == 0).
- mem_addr  output  ADDR_W  memory address.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe (one cycle).
- data_oe  output  1  accumulator/ALU drive enable onto the memory data bus.
- alu_opcode  output  3  IR[7:5] to ALU.
- acc_ld  output  1  accumulator load enable (one cycle).
- pc  output  ADDR_W  current PC (debug/visibility).
- halted  output  1  CPU stopped on HLT.

Behaviour:
- Reset is asynchronous, active-high, and effective immediately, including mid-instruction.
  - State = INST_ADDR; PC = 0; IR = 0; halted = 0.
  - mem_rd = mem_wr = data_oe = acc_ld = 0; mem_addr = 0; alu_opcode = 0.
  - Any in-flight write is aborted: mem_wr drops combinationally.
- Sequencer: 8 phases, one clock each, in fixed order:
  - INST_ADDR -> INST_FETCH -> INST_LOAD -> IDLE -> OP_ADDR -> OP_FETCH -> ALU_OP -> STORE -> INST_ADDR.
  - Plus a terminal HALT state.
  - Exactly 8 cycles per non-halting instruction.
- ALUOP = ADD | AND | XOR | LDA, decoded from IR[7:5].
- mem_addr: PC during INST_ADDR, INST_FETCH, INST_LOAD and IDLE; IR[4:0] in all other states, including HALT.
- mem_rd:
  - Asserted in INST_FETCH, INST_LOAD and IDLE.
  - Asserted in OP_FETCH, ALU_OP and STORE when ALUOP.
  - 0 otherwise.
- IR load: IR <= mem_rdata at the clock edge ending INST_LOAD.
- alu_opcode = IR[7:5] combinationally, all states.
- OP_ADDR:
  - If opcode == HLT: next state HALT, halted <= 1, PC unchanged (pc shows the HLT address).
  - Otherwise: PC <= PC + 1 (mod 2^ADDR_W; 31 -> 0).
- ALU_OP, evaluated at the edge ending it:
  - SKZ and alu_zero == 1: PC <= PC + 1 (skip next instruction, wraps).
  - JMP: PC <= IR[4:0].
  - Otherwise PC holds.
  - alu_zero is sampled only in this state.
- data_oe: asserted in ALU_OP and STORE when opcode == STO.
- mem_wr: asserted in STORE only, when opcode == STO (single-cycle pulse; address = IR[4:0]).
- acc_ld: asserted in STORE only, when ALUOP. The accumulator captures the ALU output at the edge ending STORE.
- HLT, SKZ, JMP, STO never assert acc_ld.
- HALT state:
  - Outputs: all strobes 0, halted = 1.
  - PC and IR frozen; exits only via rst.
- Outputs are combinational decodes of state and IR only. No path from mem_rdata or alu_zero to any output.
- No simultaneous-event conflicts: SKZ and JMP are mutually exclusive by opcode. A JMP target of the current PC is legal (tight loop).

Test Plan:
- Reset then release; mem[0] = 8'hA3 (LDA 3), mem[3] = 8'h05 -> cycles 0–3 mem_addr = 0, mem_rd high in cycles 1–3; IR = 8'hA3 after cycle 2; mem_addr = 3 in cycles 4–7; acc_ld pulses in cycle 7 only; PC = 1 at instruction end.
- Program LDA 3; ADD 4 (8'h44) with mem[4] = 8'h07 -> second instruction alu_opcode = 2, acc_ld in its STORE phase, PC = 2 after 16 cycles.
- SKZ (8'h20) at PC = 5 with alu_zero = 1 -> PC = 7 after instruction; repeat with alu_zero = 0 -> PC = 6.
- JMP 8'hFF at PC = 10 -> PC = 31; next fetch mem_addr = 31. Instruction at 31 (non-jump) -> PC wraps to 0.
- STO 8'hC9 -> data_oe high in ALU_OP and STORE; mem_wr high exactly one cycle (STORE) with mem_addr = 9; mem_rd = 0 throughout operand phases.
- HLT (8'h00) at PC = 2 -> halted = 1 from the cycle after OP_ADDR; pc stays 2; no strobes for 20+ cycles. Assert rst during a STO's STORE phase -> mem_wr drops immediately; state, pc and halted return to reset values.
